// File: rtl/receiver.sv
// UART receive path: 16x oversampled 8-bit deframer feeding an 8-entry FIFO.
// Define RECEIVER_PARITY_EN to insert an even-parity bit between data and stop.
module receiver (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud,
    input  logic       i_rx,
    input  logic       i_read,
    output logic [7:0] o_D,
    output logic       o_valid,
    output logic       o_full,
    output logic       o_overrun,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef RECEIVER_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state;
    logic       sync1, rx_s;
    logic [3:0] cnt;
    logic [2:0] bcnt;
    logic [7:0] sh;
    logic [7:0] mem [8];
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
    logic       stop_tick, par_bad, push_req, push, pop;

    assign stop_tick = (state == STOP) && i_baud && (cnt == 4'd15);

`ifdef RECEIVER_PARITY_EN
    logic par;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{sh, par};
`else
    assign par_bad = 1'b0;
`endif

    assign push_req = stop_tick && rx_s && !par_bad;
    assign pop      = i_read && (count != 4'd0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = push_req && ((count != 4'd8) || pop);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            bcnt  <= 3'd0;
            sh    <= 8'd0;
`ifdef RECEIVER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= 4'd0;
                    end
                end
                START: begin
                    if (i_baud) begin
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (!rx_s) begin
                                state <= DATA;
                                bcnt  <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_baud) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            sh   <= {rx_s, sh[7:1]};
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == 3'd7) begin
                                cnt <= 4'd0;
`ifdef RECEIVER_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef RECEIVER_PARITY_EN
                PARITY: begin
                    if (i_baud) begin
                        if (cnt == 4'd15) begin
                            par   <= rx_s;
                            state <= STOP;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_baud) begin
                        if (cnt == 4'd15) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= stop_tick && !rx_s;
            o_overrun   <= push_req && (count == 4'd8) && !pop;
        end
    end

`ifdef RECEIVER_PARITY_EN
    // Frame error wins: parity is only reported when the stop bit is good.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_parity_err <= 1'b0;
        else        o_parity_err <= stop_tick && rx_s && par_bad;
    end
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'd0;
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sh;
                wr_ptr      <= wr_ptr + 3'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 3'd1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign o_D     = mem[rd_ptr];
    assign o_valid = (count != 4'd0);
    assign o_full  = (count == 4'd8);

endmodule

// File: tb/tb_receiver.sv
// Directed-plus-random bench for receiver: frames are serialised at 16 ticks per bit
// and the received bytes/pulses are predicted by a queue model of the FIFO.
module tb_receiver;

`ifdef RECEIVER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] d_out;
    logic       valid, full, overrun, frame_err, parity_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int n_fe = 0, n_ov = 0, n_pe = 0, n_wide = 0;
    logic p_fe = 1'b0, p_ov = 1'b0, p_pe = 1'b0;

    logic       pre_valid, s_valid, s_fe, s_ov, s_pe;
    logic [7:0] pre_head, s_d;

    receiver dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_baud       (baud),
        .i_rx         (rx),
        .i_read       (rd),
        .o_D          (d_out),
        .o_valid      (valid),
        .o_full       (full),
        .o_overrun    (overrun),
        .o_frame_err  (frame_err),
        .o_parity_err (parity_err)
    );

    // Clock and 16x baud enable (one cycle in four).
    always #5 clk = ~clk;

    initial begin
        int bdiv;
        bdiv = 0;
        forever begin
            @(posedge clk);
            #2;
            bdiv = (bdiv + 1) % 4;
            baud = (bdiv == 0);
        end
    end

    // Pulse monitor: counts pulses and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_fe = 1'b0;
            p_ov = 1'b0;
            p_pe = 1'b0;
        end else begin
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (parity_err) n_pe++;
            if ((frame_err && p_fe) || (overrun && p_ov) || (parity_err && p_pe)) n_wide++;
            p_fe = frame_err;
            p_ov = overrun;
            p_pe = parity_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (baud) k++;
        end
    endtask

    task automatic check_counts(input string tag);
        #1;
        chk({tag, "_fe_cnt"}, n_fe, exp_fe);
        chk({tag, "_ov_cnt"}, n_ov, exp_ov);
        chk({tag, "_pe_cnt"}, n_pe, exp_pe);
    endtask

    // One frame; the stop sample falls on the tick 8 ticks into the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input bit pop_at_push);
        logic popping, e_fe, e_ov, e_pe;
        if (!baud) wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        if (PAR_EN) begin
            rx = (^d) ^ par_flip;
            wait_ticks(16);
        end
        rx = stop_bit;
        wait_ticks(8);
        pre_valid = valid;
        pre_head  = d_out;
        popping   = pop_at_push && valid;
        rd = pop_at_push;
        @(negedge clk);
        rd = 1'b0;
        s_valid = valid;
        s_d     = d_out;
        s_fe    = frame_err;
        s_ov    = overrun;
        s_pe    = parity_err;
        if (popping) begin
            chk("pop_head", pre_head, exp_q[0]);
            void'(exp_q.pop_front());
        end
        e_fe = !stop_bit;
        e_pe = stop_bit && PAR_EN && par_flip;
        e_ov = stop_bit && !e_pe && (exp_q.size() == 8);
        if (stop_bit && !e_pe && !e_ov) exp_q.push_back(d);
        if (e_fe) exp_fe++;
        if (e_pe) exp_pe++;
        if (e_ov) exp_ov++;
        chk("fe_pulse", s_fe, e_fe);
        chk("pe_pulse", s_pe, e_pe);
        chk("ov_pulse", s_ov, e_ov);
        chk("valid_after", s_valid, exp_q.size() != 0);
        rx = 1'b1;
        wait_ticks(8);
        if (!stop_bit) wait_ticks(16);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            chk("drain_valid", valid, 1);
            chk("drain_d", d_out, exp_q[0]);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            void'(exp_q.pop_front());
        end
        chk("drain_empty", valid, 0);
    endtask

    initial begin
        logic [7:0] b;
        // Reset and idle line
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_full", full, 0);
        chk("rst_d", d_out, 8'h00);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_valid", valid, 0);
        chk("idle_full", full, 0);
        chk("idle_d", d_out, 8'h00);
        check_counts("idle");

        // Single frame 0xA5 and one read
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_pre_valid", pre_valid, 0);
        chk("a5_valid", s_valid, 1);
        chk("a5_d", s_d, 8'hA5);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        void'(exp_q.pop_front());
        chk("a5_read_valid", valid, 0);

        // Nine back-to-back frames: fill, overrun, drain across pointer wrap
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 7) chk("full_after_8", full, 1);
        end
        chk("full_after_9", full, 1);
        check_counts("overrun");
        drain();
        chk("not_full", full, 0);

        // Full FIFO with a pop on the push edge: accepted, no overrun
        for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        chk("pp_full", full, 1);
        drain();

        // Framing error then a good frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("fe_valid", valid, 0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        chk("fe_next_d", s_d, 8'h11);
        drain();
        check_counts("frame");

        // Random frames with occasional bad stop bits and pops at the push edge
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) != 0), 1'b0, ($urandom_range(0, 2) == 0));
        end
        drain();
        check_counts("random");

        // Glitch shorter than half a bit: false start
        if (!baud) wait_ticks(1);
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        chk("glitch_valid", valid, 0);
        check_counts("glitch");
        send_frame(8'h6E, 1'b1, 1'b0, 1'b0);
        chk("glitch_next_d", s_d, 8'h6E);

        // Parity (only meaningful when the option is built in)
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 1'b0);
            send_frame(8'h07, 1'b1, 1'b1, 1'b0);
            check_counts("parity");
        end
        drain();

        // Reset in the middle of data bit 4 with bytes queued
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h9B, 1'b1, 1'b0, 1'b0);
        if (!baud) wait_ticks(1);
        b = 8'hE9;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = b[4];
        wait_ticks(8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_d", d_out, 8'h00);
        chk("mid_rst_pulses", {frame_err, overrun, parity_err}, 0);
        exp_q.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(200);
        chk("post_rst_valid", valid, 0);
        check_counts("post_rst");
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        drain();

        check_counts("final");
        chk("pulse_width", n_wide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
